// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between the Fetcher and the memory controller.
// Hit latency 1 cycle; a miss holds mc_req until mc_done; rdy=0 freezes everything; rob_clear drops results.
module icache #(
    parameter int IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        rdy_i,
    input  logic        rob_clear_i,
    input  logic        fetch_start_i,
    input  logic [31:0] fetch_pc_i,
    output logic        instr_ready_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_addr_o,
    output logic        mc_req_o,
    output logic [31:0] mc_addr_o,
    input  logic        mc_done_i,
    input  logic [31:0] mc_data_i
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic {
        S_IDLE,
        S_MISS
    } state_t;

    state_t             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES];
    logic               ready_q, ready_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        addr_q, addr_d;
    logic               mc_req_q, mc_req_d;
    logic [31:0]        mc_addr_q, mc_addr_d;
    logic               drop_q, drop_d;
    logic [31:0]        pc_q, pc_d;

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               hit;
    logic               fill_en;
    logic               unused_pc_bits;

    assign req_idx  = fetch_pc_i[IDX_W+1:2];
    assign req_tag  = fetch_pc_i[31:IDX_W+2];
    assign fill_idx = pc_q[IDX_W+1:2];
    assign fill_tag = pc_q[31:IDX_W+2];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign unused_pc_bits = ^fetch_pc_i[1:0];

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        ready_d   = ready_q;
        instr_d   = instr_q;
        addr_d    = addr_q;
        mc_req_d  = mc_req_q;
        mc_addr_d = mc_addr_q;
        drop_d    = drop_q;
        pc_d      = pc_q;
        fill_en   = 1'b0;
        if (rdy_i) begin
            ready_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    // ready_q guard: the Fetcher still holds start_fetch during the pulse cycle
                    if (fetch_start_i && !ready_q && !rob_clear_i) begin
                        if (hit) begin
                            ready_d = 1'b1;
                            instr_d = data_q[req_idx];
                            addr_d  = fetch_pc_i;
                        end else begin
                            state_d   = S_MISS;
                            mc_req_d  = 1'b1;
                            mc_addr_d = {fetch_pc_i[31:2], 2'b00};
                            pc_d      = fetch_pc_i;
                        end
                    end
                end
                S_MISS: begin
                    if (rob_clear_i) begin
                        drop_d = 1'b1;
                    end
                    // The fill always lands, even for a flushed request
                    if (mc_done_i) begin
                        fill_en           = 1'b1;
                        valid_d[fill_idx] = 1'b1;
                        mc_req_d          = 1'b0;
                        state_d           = S_IDLE;
                        drop_d            = 1'b0;
                        if (!drop_q && !rob_clear_i) begin
                            ready_d = 1'b1;
                            instr_d = mc_data_i;
                            addr_d  = pc_q;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            valid_q   <= '0;
            ready_q   <= 1'b0;
            instr_q   <= '0;
            addr_q    <= '0;
            mc_req_q  <= 1'b0;
            mc_addr_q <= '0;
            drop_q    <= 1'b0;
            pc_q      <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
            instr_q   <= instr_d;
            addr_q    <= addr_d;
            mc_req_q  <= mc_req_d;
            mc_addr_q <= mc_addr_d;
            drop_q    <= drop_d;
            pc_q      <= pc_d;
        end
    end

    // Tag/data storage needs no reset: valid bits gate every read
    always_ff @(posedge clk) begin
        if (!rst_i && fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mc_data_i;
        end
    end

    assign instr_ready_o = ready_q;
    assign instr_o       = instr_q;
    assign instr_addr_o  = addr_q;
    assign mc_req_o      = mc_req_q;
    assign mc_addr_o     = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
// Randomised scoreboard bench for icache: expected deliveries are queued at issue, a monitor pops them on each pulse.
module tb_icache;

    localparam int IDX_W = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rob_clr_t;
    logic        clr_resp;
    logic        rob_clear;
    logic        fetch_start;
    logic [31:0] fetch_pc;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_addr;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done;
    logic [31:0] mc_data;
    logic        clr_on_done;

    assign rob_clear = rob_clr_t | clr_resp;

    icache #(.IDX_W(IDX_W)) dut (
        .clk           (clk),
        .rst_i         (rst),
        .rdy_i         (rdy),
        .rob_clear_i   (rob_clear),
        .fetch_start_i (fetch_start),
        .fetch_pc_i    (fetch_pc),
        .instr_ready_o (instr_ready),
        .instr_o       (instr),
        .instr_addr_o  (instr_addr),
        .mc_req_o      (mc_req),
        .mc_addr_o     (mc_addr),
        .mc_done_i     (mc_done),
        .mc_data_i     (mc_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
    } exp_t;

    exp_t        sbq [$];
    logic [31:0] mcq [$];
    logic [31:0] memv [logic [31:0]];
    int          cached [int];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (!memv.exists(a)) memv[a] = $urandom;
        return memv[a];
    endfunction

    // Output monitor: every pulse must match the oldest expected delivery
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (instr_ready === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("instr", instr, e.instr);
                    chk("instr_addr", instr_addr, e.addr);
                end
            end
        end
    end

    // Memory controller model: random latency, mc_done held until taken under rdy=1
    initial begin
        logic [31:0] a;
        logic        r;
        int          d;
        mc_done  = 1'b0;
        mc_data  = '0;
        clr_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (mc_req === 1'b1 && rst === 1'b0) begin
                if (mcq.size() == 0) chk("unexpected_mc_req", 32'd1, 32'd0);
                else chk("mc_addr", mc_addr, mcq.pop_front());
                a = mc_addr;
                d = $urandom_range(2, 5);
                repeat (d) @(posedge clk);
                #1;
                mc_done  = 1'b1;
                mc_data  = memv.exists(a) ? memv[a] : 32'h0;
                clr_resp = clr_on_done;
                do begin
                    @(negedge clk);
                    r = rdy;
                    @(posedge clk);
                end while (!r);
                #1;
                mc_done  = 1'b0;
                clr_resp = 1'b0;
                mc_data  = $urandom;
            end
        end
    end

    // mode: 0 plain, 1 flush one cycle after a miss, 2 flush at the accept edge,
    //       3 flush coincident with mc_done, 4 rdy low for 4 cycles mid-miss
    task automatic fetch(input logic [31:0] pc, input int mode);
        logic [31:0] al;
        int          idx;
        bit          hit;
        bit          acc;
        exp_t        e;
        int          i;
        al  = {pc[31:2], 2'b00};
        idx = int'(pc[IDX_W+1:2]);
        hit = cached.exists(idx) && (cached[idx] == int'(pc[31:2]));
        acc = (mode != 2);
        if (acc) begin
            e.instr = mem_word(al);
            e.addr  = pc;
            if (hit || !(mode == 1 || mode == 3)) sbq.push_back(e);
            if (!hit) begin
                mcq.push_back(al);
                cached[idx] = int'(pc[31:2]);
            end
        end
        clr_on_done = (mode == 3 && !hit);
        fetch_start = 1'b1;
        fetch_pc    = pc;
        rob_clr_t   = (mode == 2);
        @(posedge clk);
        #1;
        rob_clr_t = 1'b0;
        if (!acc || !hit) fetch_start = 1'b0;
        if (mode == 1 && !hit) rob_clr_t = 1'b1;
        if (mode == 4 && !hit) rdy = 1'b0;
        @(negedge clk);
        if (!acc) begin
            chk("flush_no_pulse", 32'(instr_ready), 32'd0);
            chk("flush_no_req", 32'(mc_req), 32'd0);
        end else if (hit) begin
            chk("hit_latency", 32'(instr_ready), 32'd1);
            chk("hit_no_req", 32'(mc_req), 32'd0);
        end else begin
            chk("miss_req", 32'(mc_req), 32'd1);
            chk("miss_no_pulse", 32'(instr_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        fetch_start = 1'b0;
        rob_clr_t   = 1'b0;
        if (mode == 4 && !hit) begin
            repeat (3) begin
                @(negedge clk);
                chk("frozen_req", 32'(mc_req), 32'd1);
                chk("frozen_addr", mc_addr, al);
                chk("frozen_pulse", 32'(instr_ready), 32'd0);
            end
            @(posedge clk);
            #1;
            rdy = 1'b1;
        end
        i = 0;
        while (mc_req !== 1'b0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (i >= 200) chk("miss_timeout", 32'd1, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        clr_on_done = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pc;
        int          mode;
        rst         = 1'b1;
        rdy         = 1'b1;
        rob_clr_t   = 1'b0;
        fetch_start = 1'b0;
        fetch_pc    = '0;
        clr_on_done = 1'b0;
        memv[32'h4] = 32'h0000_0013;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_addr", instr_addr, 32'd0);
        chk("rst_mc_req", 32'(mc_req), 32'd0);
        chk("rst_mc_addr", mc_addr, 32'd0);
        @(posedge clk);
        #1;

        fetch(32'h4, 0);
        fetch(32'h4, 0);
        fetch(32'h104, 0);
        fetch(32'h4, 0);
        fetch(32'h204, 1);
        fetch(32'h204, 0);
        fetch(32'h204, 2);
        fetch(32'h304, 3);
        fetch(32'h304, 0);
        fetch(32'h404, 4);
        fetch(32'h404, 0);

        repeat (250) begin
            pc   = (32'($urandom_range(0, 3)) << (IDX_W + 2)) | (32'($urandom_range(0, 7)) << 2);
            mode = $urandom_range(0, 9);
            if (mode > 4) mode = 0;
            fetch(pc, mode);
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        chk("mc_queue_empty", 32'(mcq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
